// File: rtl/pin_signal_gen_pkg.sv
// Shared encodings for the per-pin signal engine: commands, modes, register map, FSM states.
package pinctrl_pkg;

    localparam logic [15:0] CMD_START = 16'd1;
    localparam logic [15:0] CMD_STOP  = 16'd2;
    localparam logic [15:0] CMD_CLEAR = 16'd3;

    localparam logic [1:0] MODE_CONST  = 2'd0;
    localparam logic [1:0] MODE_PWM    = 2'd1;
    localparam logic [1:0] MODE_SAMPLE = 2'd2;

    localparam logic [2:0] REG_CMD    = 3'd0;
    localparam logic [2:0] REG_MODE   = 3'd1;
    localparam logic [2:0] REG_DUTY   = 3'd2;
    localparam logic [2:0] REG_ANTI   = 3'd3;
    localparam logic [2:0] REG_CYCLES = 3'd4;
    localparam logic [2:0] REG_FLAGS  = 3'd5;
    localparam logic [2:0] REG_STATUS = 3'd6;
    localparam logic [2:0] REG_SAMPLE = 3'd7;

    localparam int GLOBAL_ADDR = 0;
    localparam int WIN_WORDS   = 8;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_CONST  = 5'b00010,
        ST_HIGH   = 5'b00100,
        ST_LOW    = 5'b01000,
        ST_SAMPLE = 5'b10000
    } state_t;

    // Compact 3-bit state code reported in STATUS[14:12].
    function automatic logic [2:0] state_code(input state_t s);
        logic [2:0] c;
        c = 3'd0;
        case (s)
            ST_CONST:  c = 3'd1;
            ST_HIGH:   c = 3'd2;
            ST_LOW:    c = 3'd3;
            ST_SAMPLE: c = 3'd4;
            default:   c = 3'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pin_signal_gen_if.sv
// Shared 21-bit register bus seen by every pin_signal_gen instance.
interface pin_signal_gen_if #(
    parameter int ADDR_W = 21
);
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic [15:0]       data_in;
    logic [15:0]       data_out;

    modport master (output addr, output wr_en, output data_in, input data_out);
    modport slave  (input addr, input wr_en, input data_in, output data_out);
endinterface

// File: rtl/pin_signal_gen_sync.sv
// Two-flop synchroniser bringing the asynchronous pin level into the clk domain.
module pin_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;
endmodule

// File: rtl/pin_signal_gen.sv
// Per-pin signal engine: constant level, counted/free-running PWM, periodic sampling.
// Define PINCTRL_READBACK_EN to build the register readback path (data_out, STATUS).
module pin_signal_gen
    import pinctrl_pkg::*;
#(
    parameter int POSITION = 16,
    parameter int CNT_W    = 16,
    parameter int ADDR_W   = 21
) (
    input  logic                   clk,
    input  logic                   reset,
    pin_signal_gen_if.slave        bus,
    input  logic                   pin_in,
    output logic                   pin_output,
    output logic                   pin_oe,
    output logic                   busy
);

    logic [ADDR_W-1:0] rel;
    logic [2:0]        off;
    logic              local_hit, global_hit, wr_local, wr_global;
    logic              cmd_start, cmd_stop, cmd_clear;

    logic [1:0]        mode;
    logic [CNT_W-1:0]  duty, anti, cycles;
    logic [1:0]        flags;
    logic              run_inf;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cyc_left;
    logic [15:0]       sample;
    logic              pin_s;

    // A DUTY/ANTI of 0 behaves as 1; counters run from N-1 down to 0.
    function automatic logic [CNT_W-1:0] cnt_load(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    // Addresses below POSITION wrap to large values, so one compare bounds the window.
    assign rel        = bus.addr - ADDR_W'(POSITION);
    assign off        = rel[2:0];
    assign local_hit  = rel < ADDR_W'(WIN_WORDS);
    assign global_hit = bus.addr == ADDR_W'(GLOBAL_ADDR);
    assign wr_local   = bus.wr_en && local_hit;
    assign wr_global  = bus.wr_en && global_hit;

    assign cmd_start = (wr_local && off == REG_CMD && bus.data_in == CMD_START) ||
                       (wr_global && bus.data_in == CMD_START);
    assign cmd_stop  = (wr_local && off == REG_CMD && bus.data_in == CMD_STOP) ||
                       (wr_global && bus.data_in == CMD_STOP);
    assign cmd_clear = wr_local && off == REG_CMD && bus.data_in == CMD_CLEAR;
    assign run_inf   = flags[0];

    pin_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pin_in),
        .q     (pin_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mode   <= '0;
            duty   <= '0;
            anti   <= '0;
            cycles <= '0;
            flags  <= '0;
        end else if (wr_local) begin
            case (off)
                REG_MODE:   if (state == ST_IDLE) mode <= bus.data_in[1:0];
                REG_DUTY:   duty   <= bus.data_in[CNT_W-1:0];
                REG_ANTI:   anti   <= bus.data_in[CNT_W-1:0];
                REG_CYCLES: cycles <= bus.data_in[CNT_W-1:0];
                REG_FLAGS:  flags  <= bus.data_in[1:0];
                default: ;
            endcase
        end
    end

    // FSM with outputs registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cyc_left   <= '0;
            pin_output <= 1'b0;
            pin_oe     <= 1'b0;
            busy       <= 1'b0;
        end else if (cmd_stop) begin
            state      <= ST_IDLE;
            pin_output <= 1'b0;
            pin_oe     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_start) begin
                        case (mode)
                            MODE_CONST: begin
                                state      <= ST_CONST;
                                cyc_left   <= cycles;
                                pin_output <= flags[1];
                                pin_oe     <= 1'b1;
                                busy       <= 1'b1;
                            end
                            MODE_PWM: begin
                                if (cycles != '0 || run_inf) begin
                                    state      <= ST_HIGH;
                                    cnt        <= cnt_load(duty);
                                    cyc_left   <= cycles;
                                    pin_output <= 1'b1;
                                    pin_oe     <= 1'b1;
                                    busy       <= 1'b1;
                                end
                            end
                            MODE_SAMPLE: begin
                                state    <= ST_SAMPLE;
                                cnt      <= cnt_load(duty);
                                cyc_left <= cycles;
                                busy     <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CONST: pin_output <= flags[1];
                ST_HIGH: begin
                    if (cnt == '0) begin
                        state      <= ST_LOW;
                        cnt        <= cnt_load(anti);
                        pin_output <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (cnt == '0) begin
                        if (!run_inf && cyc_left <= CNT_W'(1)) begin
                            state    <= ST_IDLE;
                            cyc_left <= '0;
                            pin_oe   <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            state      <= ST_HIGH;
                            cnt        <= cnt_load(duty);
                            pin_output <= 1'b1;
                            if (!run_inf) cyc_left <= cyc_left - CNT_W'(1);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (cnt == '0) cnt <= cnt_load(duty);
                    else           cnt <= cnt - CNT_W'(1);
                end
                default: begin
                    state      <= ST_IDLE;
                    pin_output <= 1'b0;
                    pin_oe     <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Sample tick coincides with the SAMPLE-state counter wrapping to its reload.
    always_ff @(posedge clk) begin
        if (reset || cmd_clear) begin
            sample <= '0;
        end else if (state == ST_SAMPLE && cnt == '0 && !cmd_stop) begin
            sample <= {sample[14:0], pin_s};
        end
    end

`ifdef PINCTRL_READBACK_EN
    logic [15:0] status;
    logic [15:0] rdata_p1;

    assign status = {busy, state_code(state), 12'(cyc_left)};

    always_ff @(posedge clk) begin
        if (reset || !local_hit) begin
            rdata_p1 <= '0;
        end else begin
            case (off)
                REG_MODE:   rdata_p1 <= 16'(mode);
                REG_DUTY:   rdata_p1 <= 16'(duty);
                REG_ANTI:   rdata_p1 <= 16'(anti);
                REG_CYCLES: rdata_p1 <= 16'(cycles);
                REG_FLAGS:  rdata_p1 <= 16'(flags);
                REG_STATUS: rdata_p1 <= status;
                REG_SAMPLE: rdata_p1 <= sample;
                default:    rdata_p1 <= '0;
            endcase
        end
    end

    assign bus.data_out = rdata_p1;
`else
    assign bus.data_out = '0;
`endif

endmodule

// File: tb/tb_pin_signal_gen.sv
// Directed bench for pin_signal_gen: PWM, CONST, SAMPLE, commands, reset and readback.
module tb_pin_signal_gen;
    import pinctrl_pkg::*;

    localparam int POS = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pin_in = 1'b0;
    logic pin_output, pin_oe, busy;
    int   n_checks = 0;
    int   n_errors = 0;

    pin_signal_gen_if #(.ADDR_W(21)) bus ();

    pin_signal_gen #(.POSITION(POS), .CNT_W(16), .ADDR_W(21)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .pin_in     (pin_in),
        .pin_output (pin_output),
        .pin_oe     (pin_oe),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Readback is only built with PINCTRL_READBACK_EN; otherwise data_out stays 0.
    function automatic logic [15:0] exp_rb(input logic [15:0] v);
`ifdef PINCTRL_READBACK_EN
        return v;
`else
        return 16'h0;
`endif
    endfunction

    // Called at a negedge; the write is captured at the next posedge, returns at the following negedge.
    task automatic wr(input int a, input logic [15:0] d);
        bus.addr    = 21'(a);
        bus.data_in = d;
        bus.wr_en   = 1'b1;
        @(negedge clk);
        bus.wr_en   = 1'b0;
        bus.data_in = '0;
    endtask

    task automatic rd(input int a, output logic [15:0] d);
        bus.addr = 21'(a);
        @(negedge clk);
        d = bus.data_out;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rv;
        logic [9:0]  pat1;
        logic [3:0]  spat;
        pat1 = 10'b1110011100;
        spat = 4'b1011;
        bus.addr    = '0;
        bus.wr_en   = 1'b0;
        bus.data_in = '0;

        repeat (3) @(negedge clk);
        check("rst_pin", 32'(pin_output), 0);
        check("rst_oe", 32'(pin_oe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dout", 32'(bus.data_out), 0);
        reset = 1'b0;

        // Counted PWM: 3 high / 2 low, two cycles.
        wr(POS + 1, 16'd1);
        wr(POS + 2, 16'd3);
        wr(POS + 3, 16'd2);
        wr(POS + 4, 16'd2);
        wr(POS, CMD_START);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("pwm_pin%0d", i), 32'(pin_output), 32'(pat1[9-i]));
            check($sformatf("pwm_busy%0d", i), 32'(busy), 1);
            @(negedge clk);
        end
        check("pwm_done_busy", 32'(busy), 0);
        check("pwm_done_oe", 32'(pin_oe), 0);
        rd(POS + 6, rv);
        check("pwm_status", 32'(rv), 32'(exp_rb(16'h0000)));
        rd(POS + 2, rv);
        check("rd_duty", 32'(rv), 32'(exp_rb(16'd3)));

        // Free-running 1/1 toggle, then global stop.
        wr(POS + 5, 16'd1);
        wr(POS + 2, 16'd1);
        wr(POS + 3, 16'd1);
        wr(POS, CMD_START);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("tog_pin%0d", i), 32'(pin_output), (i % 2 == 0) ? 1 : 0);
            @(negedge clk);
        end
        wr(GLOBAL_ADDR, CMD_STOP);
        check("gstop_pin", 32'(pin_output), 0);
        check("gstop_busy", 32'(busy), 0);
        check("gstop_oe", 32'(pin_oe), 0);

        // Start while running is ignored: 2/1 pattern continues unchanged.
        wr(POS + 2, 16'd2);
        wr(POS, CMD_START);
        check("rs_s0", 32'(pin_output), 1);
        @(negedge clk);
        check("rs_s1", 32'(pin_output), 1);
        @(negedge clk);
        check("rs_s2", 32'(pin_output), 0);
        wr(POS, CMD_START);
        check("rs_s3", 32'(pin_output), 1);
        @(negedge clk);
        check("rs_s4", 32'(pin_output), 1);
        @(negedge clk);
        check("rs_s5", 32'(pin_output), 0);
        @(negedge clk);
        check("rs_s6", 32'(pin_output), 1);
        wr(POS, CMD_STOP);
        check("lstop_busy", 32'(busy), 0);

        // CYCLES=0 without run_inf: start ignored.
        wr(POS + 5, 16'd0);
        wr(POS + 4, 16'd0);
        wr(POS, CMD_START);
        check("cyc0_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        check("cyc0_busy_late", 32'(busy), 0);
        check("cyc0_oe", 32'(pin_oe), 0);

        // Constant level.
        wr(POS + 1, 16'd0);
        wr(POS + 5, 16'd2);
        wr(POS, CMD_START);
        check("const_pin", 32'(pin_output), 1);
        check("const_oe", 32'(pin_oe), 1);
        check("const_busy", 32'(busy), 1);
        rd(POS + 6, rv);
        check("const_status", 32'(rv), 32'(exp_rb(16'h9000)));
        wr(POS + 1, 16'd1);
        rd(POS + 1, rv);
        check("mode_locked", 32'(rv), 32'(exp_rb(16'd0)));
        wr(POS + 5, 16'd0);
        @(negedge clk);
        check("const_follow", 32'(pin_output), 0);
        check("const_follow_oe", 32'(pin_oe), 1);
        wr(POS, CMD_STOP);
        check("const_stop_oe", 32'(pin_oe), 0);
        check("const_stop_busy", 32'(busy), 0);

        // Sampling every 4 clocks; pattern 1,0,1,1 yields 0x000B.
        wr(POS + 1, 16'd2);
        wr(POS + 2, 16'd4);
        wr(POS, CMD_START);
        check("smp_busy", 32'(busy), 1);
        check("smp_oe", 32'(pin_oe), 0);
        for (int k = 0; k < 4; k++) begin
            pin_in = spat[3-k];
            repeat (4) @(negedge clk);
        end
        check("smp_pin", 32'(pin_output), 0);
        rd(POS + 6, rv);
        check("smp_status", 32'(rv), 32'(exp_rb(16'hC000)));
        rd(POS + 7, rv);
        check("smp_value", 32'(rv), 32'(exp_rb(16'h000B)));
        wr(POS, CMD_STOP);
        check("smp_stop_busy", 32'(busy), 0);
        rd(POS + 7, rv);
        check("smp_hold", 32'(rv), 32'(exp_rb(16'h000B)));
        wr(POS, CMD_CLEAR);
        rd(POS + 7, rv);
        check("smp_clear", 32'(rv), 0);
        rd(POS + 8, rv);
        check("out_of_window", 32'(rv), 0);

        // Reset in the middle of HIGH.
        wr(POS + 1, 16'd1);
        wr(POS + 2, 16'd3);
        wr(POS + 3, 16'd2);
        wr(POS + 4, 16'd2);
        wr(POS, CMD_START);
        @(negedge clk);
        check("pre_rst_pin", 32'(pin_output), 1);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_pin", 32'(pin_output), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_oe", 32'(pin_oe), 0);
        check("mrst_dout", 32'(bus.data_out), 0);
        reset = 1'b0;
        rd(POS + 1, rv);
        check("mrst_mode", 32'(rv), 0);
        rd(POS + 2, rv);
        check("mrst_duty", 32'(rv), 0);
        rd(POS + 4, rv);
        check("mrst_cycles", 32'(rv), 0);
        check("mrst_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pin_signal_gen.md
# pin_signal_gen

Parametrised per-pin signal engine for the mecobo FPGA. It is the successor of the single-mode PWM pin controller. One instance drives one material pin from the shared 21-bit register bus and supports three modes:
- constant level,
- counted or free-running PWM,
- periodic input sampling with readback.

Instances are tiled at distinct `POSITION` base addresses and share broadcast address 0.

## Interface
- `POSITION`, 16: word base address of this instance's register window (8 words).
- `CNT_W`, 16: width of duty, anti-duty and cycle counters (≤ 16).
- `ADDR_W`, 21: bus address width.
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high.
- `addr` in `ADDR_W`: register address.
- `wr_en` in 1: write strobe; writes happen only when high.
- `data_in` in 16: write data.
- `data_out` out 16: registered readback.
- `pin_in` in 1: asynchronous pin level, used in SAMPLE mode.
- `pin_output` out 1: driven pin level.
- `pin_oe` out 1: pin output enable; 0 in SAMPLE and IDLE.
- `busy` out 1: high in any non-IDLE state.

## Operation
**Registers** (offset from `POSITION`; address 0 is the global command):
- +0 CMD: 1 = start, 2 = stop, 3 = clear sample.
- +1 MODE: 0 = CONST, 1 = PWM, 2 = SAMPLE.
- +2 DUTY: high ticks.
- +3 ANTI: low ticks.
- +4 CYCLES.
- +5 FLAGS: bit0 = run_inf, bit1 = const level.
- +6 STATUS (read-only): {busy, state[2:0], cycles remaining[11:0]}.
- +7 SAMPLE (read-only).

**Commands**
- Global address 0 accepts start/stop with the same codes, for all instances simultaneously.
- If local and global commands arrive in the same cycle, stop wins.

**FSM states:** IDLE, CONST, HIGH, LOW, SAMPLE.
- IDLE + start:
  - MODE=0 → CONST.
  - MODE=1 → HIGH, provided CYCLES ≠ 0 or run_inf = 1; otherwise the start is ignored.
  - MODE=2 → SAMPLE.
- Start while not IDLE is ignored.
- Stop from any state → IDLE on the next edge.
- CONST: `pin_output` = FLAGS[1], `pin_oe` = 1.
- HIGH: held for DUTY ticks, then → LOW.
- LOW: held for ANTI ticks. At expiry:
  - If run_inf = 0 and the cycle count reaches 0 → IDLE.
  - Otherwise → HIGH.
- A DUTY or ANTI value of 0 is treated as 1.
- SAMPLE:
  - `pin_in` passes through a 2-flop synchroniser.
  - Every DUTY ticks, the synchronised bit shifts into SAMPLE at the LSB.
  - Runs until stop.
- Counters reload from DUTY/ANTI on each entry to HIGH/LOW. CYCLES is latched at start.
- Register writes made while running take effect at the next reload. MODE writes take effect only from IDLE.
- Counters use `CNT_W` bits. Upper `data_in` bits above `CNT_W` are ignored.
- Reset mid-operation:
  - State → IDLE.
  - All registers → 0.
  - SAMPLE → 0.

## Timing
- Start written at edge N → `busy` = 1 and the first HIGH output from edge N+1.
- PWM period is exactly DUTY + ANTI clocks. There are no dead cycles between cycles or at wrap.
- Stop at edge N → `pin_output` = 0, `pin_oe` = 0, `busy` = 0 after edge N+1.
- Readback: `data_out` at edge N+1 reflects `addr` at edge N. It is 0 for addresses outside the window.
- SAMPLE latency: `pin_in` → shift register takes 2 synchroniser cycles plus a wait until the next sample tick.
- Reset values: `pin_output` = 0, `pin_oe` = 0, `busy` = 0, `data_out` = 0.

## Configuration
- `PINCTRL_READBACK_EN`:
  - Defined: the +6/+7 readback mux and `data_out` register are built.
  - Undefined: `data_out` is tied to 0, and the STATUS logic is removed. SAMPLE mode still shifts, but its result cannot be read.

## Structure
- `pinctrl_pkg`: mode encodings, CMD codes, register offsets, state encoding (one-hot, 5 bits), global address 0.
- Sub-module `pin_sync`: 2-flop synchroniser for `pin_in`.

## Test plan
- MODE=1, DUTY=3, ANTI=2, CYCLES=2, then start → pin is high 3 / low 2 / high 3 / low 2; `busy` drops after 10 clocks; STATUS reads IDLE.
- run_inf=1, DUTY=1, ANTI=1 → toggle every clock. Global stop at address 0 → pin low and `busy` = 0 one clock later.
- MODE=0, FLAGS=2 (const level 1), start → `pin_output` = 1, `pin_oe` = 1. Stop → 0/0.
- MODE=2, DUTY=4, `pin_in` pattern 1,0,1,1 applied per 4-clock window → SAMPLE reads 0x000B.
- CYCLES=0, run_inf=0, start → `busy` remains 0. Start issued while running → period unchanged.
- Reset asserted mid-HIGH → next edge: `pin_output` = 0, `busy` = 0, all registers read 0.
